// File: rtl/collider_stim_pkg.sv
// Shared constants and types for the collider stimulus player.
package collider_stim_pkg;

  localparam int NWG   = 48;  // wiregroups per quality plane
  localparam int DEPTH = 16;  // stored frames
  localparam int W_W   = 7;   // wiregroup field width
  localparam int Q_W   = 2;   // quality field width
  localparam int NQ    = 4;   // number of quality planes
  localparam int PTR_W = 4;   // read pointer width (indexes 0..DEPTH-1)
  localparam int CNT_W = 5;   // write pointer / frame count width (0..DEPTH)

  // One frame, laid out exactly like the collider output record.
  typedef struct packed {
    logic           v2;
    logic [Q_W-1:0] q2;
    logic [W_W-1:0] w2;
    logic           v1;
    logic [Q_W-1:0] q1;
    logic [W_W-1:0] w1;
  } frame_t;

  localparam int FRAME_W = $bits(frame_t);

  // Four quality planes, index [q][w].
  typedef logic [NQ-1:0][NWG-1:0] planes_t;

  // Player FSM encoding.
  typedef logic [0:0] state_t;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  // True when a wiregroup number addresses a real wire.
  function automatic logic w_ok(input logic [W_W-1:0] w);
    return (w < 7'd48);
  endfunction

endpackage

// File: rtl/collider_stim_expand.sv
// Combinational expansion of one stored frame into four quality-plane vectors.
module stim_expand
  import collider_stim_pkg::*;
(
  input  frame_t  frame,
  output planes_t planes
);

  logic [NWG-1:0] hit1_s;
  logic [NWG-1:0] hit2_s;

  // One-hot wire masks for each hit; an invalid or out-of-range hit contributes nothing
  always_comb begin
    hit1_s = (frame.v1 && w_ok(frame.w1)) ? ({{(NWG-1){1'b0}}, 1'b1} << frame.w1) : {NWG{1'b0}};
    hit2_s = (frame.v2 && w_ok(frame.w2)) ? ({{(NWG-1){1'b0}}, 1'b1} << frame.w2) : {NWG{1'b0}};
  end

  // Route each mask onto its quality plane; hits on the same plane and wire simply OR
  always_comb begin
    planes = {(NQ*NWG){1'b0}};
    for (int p = 0; p < NQ; p++) begin
      planes[p] = ((frame.q1 == Q_W'(p)) ? hit1_s : {NWG{1'b0}}) |
                  ((frame.q2 == Q_W'(p)) ? hit2_s : {NWG{1'b0}});
    end
  end

endmodule

// File: rtl/collider_stim.sv
// Frame-list stimulus player: loads up to DEPTH hit frames, then replays them
// (optionally several passes) as registered per-quality-plane hit vectors.
module collider_stim
  import collider_stim_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           ld_en,
  input  logic [W_W-1:0] ld_w1,
  input  logic [W_W-1:0] ld_w2,
  input  logic [Q_W-1:0] ld_q1,
  input  logic [Q_W-1:0] ld_q2,
  input  logic           ld_v1,
  input  logic           ld_v2,
  input  logic           start,
  input  logic [3:0]     nrep,
  output logic [NWG-1:0] qp0,
  output logic [NWG-1:0] qp1,
  output logic [NWG-1:0] qp2,
  output logic [NWG-1:0] qp3,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           bad_w,
  output logic           ld_err
);

  frame_t             mem_r [DEPTH];
  state_t             state_r;
  logic [CNT_W-1:0]   wptr_r;
  logic [PTR_W-1:0]   rptr_r;
  logic [3:0]         pass_r;
  planes_t            qp_r;
  logic               busy_r;
  logic               done_r;
  logic               ovf_r;
  logic               bad_w_r;
  logic               ld_err_r;

  frame_t             ld_frame_s;
  logic               ld_bad_s;
  logic               full_s;
  logic               last_s;
  logic               ld_take_s;
  logic [PTR_W-1:0]   nxt_idx_s;
  frame_t             rd_frame_s;
  planes_t            exp_planes_s;

  // Sanitise the incoming frame: a valid hit on a nonexistent wire is stored as invalid
  always_comb begin
    ld_frame_s    = {ld_v2, ld_q2, ld_w2, ld_v1, ld_q1, ld_w1};
    ld_frame_s.v1 = ld_v1 & w_ok(ld_w1);
    ld_frame_s.v2 = ld_v2 & w_ok(ld_w2);
    ld_bad_s      = (ld_v1 & ~w_ok(ld_w1)) | (ld_v2 & ~w_ok(ld_w2));
  end

  // Pointer status and load acceptance (start outranks a simultaneous load)
  always_comb begin
    full_s    = (wptr_r == 5'd16);
    last_s    = ({1'b0, rptr_r} == (wptr_r - 5'd1));
    ld_take_s = (state_r == ST_IDLE) && !start && ld_en && !full_s;
  end

  // Select the frame that the output register will show next cycle
  always_comb begin
    if ((state_r == ST_PLAY) && !last_s) begin
      nxt_idx_s = rptr_r + 4'd1;
    end else begin
      nxt_idx_s = 4'd0;
    end
    rd_frame_s = mem_r[nxt_idx_s];
  end

  stim_expand u_expand (
    .frame  (rd_frame_s),
    .planes (exp_planes_s)
  );

  // Frame storage: wiped by clr, written on accepted loads; reset leaves contents alone
  always_ff @(posedge clk) begin
    if (rst_n && clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= frame_t'(20'd0);
      end
    end else if (rst_n && ld_take_s) begin
      mem_r[wptr_r[PTR_W-1:0]] <= ld_frame_s;
    end
  end

  // Player FSM, output register and sticky status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      wptr_r   <= 5'd0;
      rptr_r   <= 4'd0;
      pass_r   <= 4'd0;
      qp_r     <= {(NQ*NWG){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      bad_w_r  <= 1'b0;
      ld_err_r <= 1'b0;
    end else if (clr) begin
      state_r  <= ST_IDLE;
      wptr_r   <= 5'd0;
      rptr_r   <= 4'd0;
      pass_r   <= 4'd0;
      qp_r     <= {(NQ*NWG){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      bad_w_r  <= 1'b0;
      ld_err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (wptr_r != 5'd0) begin
              state_r <= ST_PLAY;
              rptr_r  <= 4'd0;
              pass_r  <= nrep;
              qp_r    <= exp_planes_s;
              busy_r  <= 1'b1;
            end else begin
              done_r  <= 1'b1;
            end
          end else if (ld_en) begin
            if (full_s) begin
              ovf_r <= 1'b1;
            end else begin
              wptr_r <= wptr_r + 5'd1;
              if (ld_bad_s) begin
                bad_w_r <= 1'b1;
              end
            end
          end
        end
        ST_PLAY: begin
          if (ld_en) begin
            ld_err_r <= 1'b1;
          end
          if (last_s) begin
            if (pass_r != 4'd0) begin
              pass_r <= pass_r - 4'd1;
              rptr_r <= 4'd0;
              qp_r   <= exp_planes_s;
            end else begin
              state_r <= ST_IDLE;
              rptr_r  <= 4'd0;
              qp_r    <= {(NQ*NWG){1'b0}};
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            rptr_r <= nxt_idx_s;
            qp_r   <= exp_planes_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rptr_r  <= 4'd0;
          qp_r    <= {(NQ*NWG){1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign qp0    = qp_r[0];
  assign qp1    = qp_r[1];
  assign qp2    = qp_r[2];
  assign qp3    = qp_r[3];
  assign busy   = busy_r;
  assign done   = done_r;
  assign ovf    = ovf_r;
  assign bad_w  = bad_w_r;
  assign ld_err = ld_err_r;

endmodule

// File: doc/collider_stim.md
COLLIDER_STIM -- requirements
Module: collider_stim

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 clr  in  1  clears the frame memory and sticky flags; write pointer returns to 0.
REQ-004 ld_en  in  1  write strobe for one frame.
REQ-005 ld_w1, ld_w2  in  7 each  wiregroup of hit 1 and hit 2; valid range 0..47.
REQ-006 ld_q1, ld_q2  in  2 each  quality plane of hit 1 and hit 2; values 0..3.
REQ-007 ld_v1, ld_v2  in  1 each  hit-valid bits for hit 1 and hit 2.
REQ-008 start  in  1  begins playback of the stored frames.
REQ-009 nrep  in  4  extra passes over the frame list; sampled with start; 0 means play once.
REQ-010 qp0, qp1, qp2, qp3  out  48 each  registered per-quality-plane hit vectors for the collider.
REQ-011 busy  out  1  high while playback is active.
REQ-012 done  out  1  one-cycle pulse after the final frame.
REQ-013 ovf  out  1  sticky; a write was dropped because memory was full.
REQ-014 bad_w  out  1  sticky; a loaded valid hit had w > 47.
REQ-015 ld_err  out  1  sticky; ld_en was asserted while busy.

Function
REQ-016 The frame memory holds DEPTH=16 frames; each frame is {v2,q2,w2,v1,q1,w1} (20 bits), matching the collider output format.
REQ-017 ld_en while idle and count<16 stores the frame at wptr and increments wptr; count equals wptr.
REQ-018 ld_en while idle and count=16 drops the frame and sets ovf.
REQ-019 ld_en while busy drops the frame and sets ld_err.
REQ-020 A valid hit with w>47 sets bad_w at load; that hit is stored with its v bit cleared, and the other hit in the frame is unaffected.
REQ-021 FSM states: IDLE and PLAY.
REQ-022 IDLE->PLAY on start when count>0; rptr=0; the pass counter loads nrep.
REQ-023 start sampled at edge T causes frame k of pass r to appear on qp0..qp3 during cycle T+1+r*count+k; busy is high from T+1 through the last frame.
REQ-024 Frame expansion: qp[q1][w1]=1 if v1, and qp[q2][w2]=1 if v2; all other bits are 0. Identical hits OR into the same bit.
REQ-025 At rptr=count-1: if the pass counter is >0, decrement it and set rptr to 0 with no gap cycle; otherwise go to IDLE.
REQ-026 In the cycle after the final frame: done=1 for one cycle, busy=0, and qp0..qp3 are all 0.
REQ-027 start while IDLE with count=0 produces done=1 at T+1, busy stays 0, and qp stays 0.
REQ-028 start while PLAY is ignored.
REQ-029 clr while PLAY aborts playback: next cycle is IDLE, qp=0, no done pulse, memory is empty, and flags are cleared.
REQ-030 In IDLE, qp0..qp3 are all 0.
REQ-031 Memory contents persist across playbacks until clr or reset, so start can be issued repeatedly.

Reset
REQ-032 When rst_n=0 at an edge: state=IDLE, wptr=0, rptr=0, pass counter=0, qp0..qp3=0, busy=0, done=0, ovf=0, bad_w=0, ld_err=0.
REQ-033 Reset mid-playback terminates playback with no done pulse; frame memory contents need not be cleared.
REQ-034 Reset has priority over clr, clr over start, and start over ld_en in the same cycle.

Structure
REQ-035 A shared package holds NWG=48, DEPTH=16, the wiregroup width (7), the quality width (2), the frame record type, and the FSM state type.
REQ-036 One combinational sub-module, stim_expand, converts one frame to four 48-bit planes; the output register lives in collider_stim.

Verification
REQ-037 Load 1 frame {w1=5,q1=3,v1=1, w2=40,q2=0,v2=1}, then start, nrep=0 -> at T+1 qp3=1<<5, qp0=1<<40, qp1=qp2=0; done at T+2.
REQ-038 Load 3 frames, then start, nrep=2 -> 9 consecutive frames in order 0,1,2,0,1,2,0,1,2; busy high for 9 cycles; done at T+10.
REQ-039 Load 17 frames -> first 16 are stored and ovf=1; playback shows 16 frames.
REQ-040 Load frame w1=50,v1=1, w2=47,q2=2,v2=1 -> bad_w=1; on playback only qp2[47]=1.
REQ-041 ld_en and start during playback -> ld_err=1, sequence unchanged; clr mid-pass -> qp=0 next cycle, no done pulse.
REQ-042 Loopback into collider with frame {w1=10,q1=2,w2=20,q2=1} -> collider outputs w1=10, q1=2, w2=20, q2=1, v1=v2=1.
